r88_fetch_seq: RTL and testbench

Parametrised fetch/sequencing front end for the Rocket88 core, successor to the single-width decoder's flag and interrupt handling. It fetches an opcode plus a variable number of operand bytes through a ready-qualified memory read handshake, assembles them into an instruction packet, and hands the packet to the execute stage with a valid/ack handshake. At every instruction boundary it arbitrates reset, NMI and IRQ entry. It also owns the processor flag register, with masked updates from execute and a flag snapshot on interrupt entry.

---
 rtl/r88_fetch_seq.sv | 158 +++++++++++++++
 tb/tb_r88_fetch_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r88_fetch_seq.sv
// Rocket88 fetch/sequencing front end: fetches opcode plus operand bytes, issues
// instruction packets to execute, arbitrates reset/NMI/IRQ entry and owns the flag register.
module r88_fetch_seq #(
    parameter int                DATA_W    = 8,
    parameter int                MAX_OPND  = 2,
    parameter int                OPND_W    = DATA_W * MAX_OPND,
    parameter logic [OPND_W-1:0] RESET_VEC = 16'hFFFC,
    parameter logic [OPND_W-1:0] NMI_VEC   = 16'hFFFA,
    parameter logic [OPND_W-1:0] IRQ_VEC   = 16'hFFFE
) (
    input  logic              sysClock,
    input  logic              resetReq,
    output logic              readMem,
    input  logic              memReady,
    input  logic [DATA_W-1:0] intD,
    output logic              incPC,
    input  logic              nmiReq,
    input  logic              irq,
    output logic              instValid,
    input  logic              instAck,
    output logic [DATA_W-1:0] instOp,
    output logic [OPND_W-1:0] instOpnd,
    output logic [1:0]        instKind,
    input  logic              flagWr,
    input  logic [5:0]        flagMask,
    input  logic [5:0]        flagIn,
    output logic [5:0]        flags,
    output logic [5:0]        flagsSaved
);

    typedef enum logic [1:0] {
        FETCH_OP,
        FETCH_OPND,
        ISSUE
    } stateT;

    localparam logic [1:0] KIND_NORMAL = 2'b00;
    localparam logic [1:0] KIND_NMI    = 2'b01;
    localparam logic [1:0] KIND_IRQ    = 2'b10;
    localparam logic [1:0] KIND_RESET  = 2'b11;
    localparam logic [1:0] MAX_CNT     = 2'(MAX_OPND);
    localparam logic [5:0] FLAGS_INIT  = 6'b100010;
    localparam int         FLAG_I      = 5;

    stateT      state;
    logic [1:0] cnt;
    logic [1:0] idx;
    logic       nmiPend;
    logic       nmiPrev;

    logic       accept;
    logic       nmiEdge;
    logic       boundary;
    logic       takeNmi;
    logic       takeIrq;
    logic [1:0] opCnt;
    logic [5:0] flagsWritten;

    assign incPC   = readMem & memReady;
    assign accept  = incPC;
    assign nmiEdge = nmiReq & ~nmiPrev;

    // Boundary decisions look at the flags registered at the start of the cycle.
    assign boundary = (state == ISSUE) & instValid & instAck;
    assign takeNmi  = boundary & nmiPend;
    assign takeIrq  = boundary & ~nmiPend & irq & flags[FLAG_I];

    // Operand count comes from the top two opcode bits, clamped to what the packet can hold.
    assign opCnt = (intD[DATA_W-1 -: 2] > MAX_CNT) ? MAX_CNT : intD[DATA_W-1 -: 2];

    assign flagsWritten = flagWr ? ((flags & ~flagMask) | (flagIn & flagMask)) : flags;

    always_ff @(posedge sysClock) begin
        if (resetReq) begin
            state      <= ISSUE;
            instValid  <= 1'b0;
            readMem    <= 1'b0;
            instKind   <= KIND_RESET;
            instOp     <= '0;
            instOpnd   <= RESET_VEC;
            cnt        <= '0;
            idx        <= '0;
            nmiPend    <= 1'b0;
            nmiPrev    <= 1'b0;
            flags      <= FLAGS_INIT;
            flagsSaved <= '0;
        end else begin
            nmiPrev <= nmiReq;
            nmiPend <= nmiEdge | (nmiPend & ~takeNmi);

            flags <= flagsWritten;
            if (takeNmi | takeIrq) begin
                flagsSaved <= flagsWritten;
                // NOTE: non-blocking, so this later I-bit write wins over the masked update above.
                flags[FLAG_I] <= 1'b0;
            end

            case (state)
                FETCH_OP: begin
                    if (accept) begin
                        instOp   <= intD;
                        instOpnd <= '0;
                        instKind <= KIND_NORMAL;
                        cnt      <= opCnt;
                        idx      <= '0;
                        if (opCnt == 2'd0) begin
                            state     <= ISSUE;
                            readMem   <= 1'b0;
                            instValid <= 1'b1;
                        end else begin
                            state <= FETCH_OPND;
                        end
                    end
                end

                FETCH_OPND: begin
                    if (accept) begin
                        instOpnd[idx*DATA_W +: DATA_W] <= intD;
                        idx <= idx + 2'd1;
                        if (idx == cnt - 2'd1) begin
                            state     <= ISSUE;
                            readMem   <= 1'b0;
                            instValid <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    if (!instValid) begin
                        // First cycle out of reset: present the reset packet, ignore any ack.
                        instValid <= 1'b1;
                    end else if (instAck) begin
                        if (takeNmi) begin
                            instKind <= KIND_NMI;
                            instOp   <= '0;
                            instOpnd <= NMI_VEC;
                        end else if (takeIrq) begin
                            instKind <= KIND_IRQ;
                            instOp   <= '0;
                            instOpnd <= IRQ_VEC;
                        end else begin
                            state     <= FETCH_OP;
                            readMem   <= 1'b1;
                            instValid <= 1'b0;
                        end
                    end
                end

                default: begin
                    state     <= FETCH_OP;
                    readMem   <= 1'b1;
                    instValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r88_fetch_seq.sv
// Self-checking bench for r88_fetch_seq: directed fetch/interrupt/reset steps plus randomized
// instruction streams, checked against a transaction-level model of packets and flags.
module tb_r88_fetch_seq;

    localparam int         DATA_W      = 8;
    localparam int         MAX_OPND    = 2;
    localparam int         OPND_W      = DATA_W * MAX_OPND;
    localparam logic [5:0] FLAGS_RESET = 6'b100010;

    logic              sysClock;
    logic              resetReq;
    logic              readMem;
    logic              memReady;
    logic [DATA_W-1:0] intD;
    logic              incPC;
    logic              nmiReq;
    logic              irq;
    logic              instValid;
    logic              instAck;
    logic [DATA_W-1:0] instOp;
    logic [OPND_W-1:0] instOpnd;
    logic [1:0]        instKind;
    logic              flagWr;
    logic [5:0]        flagMask;
    logic [5:0]        flagIn;
    logic [5:0]        flags;
    logic [5:0]        flagsSaved;

    int checks   = 0;
    int failures = 0;

    logic [5:0]        mFlags;
    logic [DATA_W-1:0] expOp;
    logic [OPND_W-1:0] expOpnd;

    r88_fetch_seq #(
        .DATA_W    (DATA_W),
        .MAX_OPND  (MAX_OPND),
        .RESET_VEC (16'hFFFC),
        .NMI_VEC   (16'hFFFA),
        .IRQ_VEC   (16'hFFFE)
    ) dut (
        .sysClock   (sysClock),
        .resetReq   (resetReq),
        .readMem    (readMem),
        .memReady   (memReady),
        .intD       (intD),
        .incPC      (incPC),
        .nmiReq     (nmiReq),
        .irq        (irq),
        .instValid  (instValid),
        .instAck    (instAck),
        .instOp     (instOp),
        .instOpnd   (instOpnd),
        .instKind   (instKind),
        .flagWr     (flagWr),
        .flagMask   (flagMask),
        .flagIn     (flagIn),
        .flags      (flags),
        .flagsSaved (flagsSaved)
    );

    initial sysClock = 1'b0;
    always #5 sysClock = ~sysClock;

    initial begin
        #200_000;
        $display("FAIL watchdog expired before the summary line");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge sysClock);
        #1;
    endtask

    task automatic ack();
        instAck = 1'b1;
        tick();
        instAck = 1'b0;
    endtask

    task automatic checkPacket(input string tag, input logic [1:0] kind, input logic [7:0] op,
                               input logic [15:0] opnd);
        check({tag, "_valid"}, instValid, 1);
        check({tag, "_kind"}, instKind, kind);
        check({tag, "_op"}, instOp, op);
        check({tag, "_opnd"}, instOpnd, opnd);
    endtask

    task automatic writeFlags(input logic [5:0] m, input logic [5:0] v);
        flagWr   = 1'b1;
        flagMask = m;
        flagIn   = v;
        tick();
        flagWr   = 1'b0;
        flagMask = '0;
        flagIn   = '0;
        mFlags   = (mFlags & ~m) | (v & m);
        check("flags_write", flags, mFlags);
    endtask

    // Acts as memory for one instruction; sN is the number of wait cycles before byte N.
    task automatic serveInst(input logic [7:0] op, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int s0, input int s1, input int s2,
                             input int s3);
        logic [7:0] stream [4];
        int         stalls [4];
        int         nOpnd;
        int         acc;
        int         waitLeft;
        int         budget;
        logic       ready;
        stream = '{op, b0, b1, b2};
        stalls = '{s0, s1, s2, s3};
        nOpnd  = int'(op) / 64;
        if (nOpnd > MAX_OPND) nOpnd = MAX_OPND;
        expOp   = op;
        expOpnd = '0;
        for (int i = 0; i < nOpnd; i++) expOpnd = expOpnd + (OPND_W'(stream[i+1]) << (8 * i));
        acc      = 0;
        waitLeft = stalls[0];
        budget   = 64;
        while (acc < nOpnd + 1 && budget > 0) begin
            budget--;
            ready    = (waitLeft == 0);
            memReady = ready;
            intD     = ready ? stream[acc] : 8'($urandom);
            #1;
            check("fetch_readMem", readMem, 1);
            check("fetch_incPC", incPC, ready);
            check("fetch_validLow", instValid, 0);
            tick();
            if (ready) begin
                acc++;
                if (acc < 4) waitLeft = stalls[acc];
            end else begin
                waitLeft--;
            end
        end
        memReady = 1'b0;
        check("fetch_reads", acc, nOpnd + 1);
        check("issue_readMem", readMem, 0);
        checkPacket("issue", 2'b00, expOp, expOpnd);
    endtask

    initial begin
        int hold;
        resetReq = 1'b1;
        memReady = 1'b0;
        intD     = '0;
        nmiReq   = 1'b0;
        irq      = 1'b0;
        instAck  = 1'b0;
        flagWr   = 1'b0;
        flagMask = '0;
        flagIn   = '0;
        mFlags   = FLAGS_RESET;

        // Reset for two cycles, then the reset packet appears.
        repeat (2) tick();
        check("rst_validLow", instValid, 0);
        check("rst_readMem", readMem, 0);
        check("rst_incPC", incPC, 0);
        resetReq = 1'b0;
        tick();
        checkPacket("rst", 2'b11, 8'h00, 16'hFFFC);
        check("rst_flags", flags, FLAGS_RESET);
        check("rst_flagsSaved", flagsSaved, 0);
        check("rst_readMem_after", readMem, 0);

        // Packet holds until acked.
        tick();
        checkPacket("rst_hold", 2'b11, 8'h00, 16'hFFFC);

        // Normal zero-wait fetch.
        ack();
        serveInst(8'h85, 8'h34, 8'h12, 8'h00, 0, 0, 0, 0);

        // Clamp: top bits 11 still only reads MAX_OPND operands.
        ack();
        serveInst(8'hC0, 8'h11, 8'h22, 8'h33, 0, 0, 0, 0);

        // Zero-fill of unused operand byte.
        ack();
        serveInst(8'h40, 8'hAB, 8'h00, 8'h00, 0, 0, 0, 0);

        // Wait states on the second operand.
        ack();
        serveInst(8'h85, 8'h78, 8'h56, 8'h00, 0, 0, 2, 0);

        // Randomized instructions with stalls, hold-off and flag writes.
        for (int n = 0; n < 24; n++) begin
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                writeFlags(6'($urandom), 6'($urandom));
                check("rnd_hold_valid", instValid, 1);
                check("rnd_hold_op", instOp, expOp);
                check("rnd_hold_opnd", instOpnd, expOpnd);
            end
            ack();
            serveInst(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 0);
            check("rnd_flags", flags, mFlags);
        end

        // Interrupt priority: NMI beats a pending IRQ.
        writeFlags(6'h3F, 6'b100011);
        ack();
        irq    = 1'b1;
        nmiReq = 1'b1;
        tick();
        nmiReq = 1'b0;
        serveInst(8'h85, 8'h34, 8'h12, 8'h00, 0, 0, 0, 0);
        ack();
        checkPacket("nmi", 2'b01, 8'h00, 16'hFFFA);
        check("nmi_flagsSaved", flagsSaved, 6'b100011);
        check("nmi_flags", flags, 6'b000011);
        mFlags = 6'b000011;

        // I=0: IRQ must not be taken at the next boundaries.
        ack();
        check("noirq1_readMem", readMem, 1);
        check("noirq1_valid", instValid, 0);
        serveInst(8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0);
        ack();
        check("noirq2_readMem", readMem, 1);
        serveInst(8'h40, 8'hAB, 8'h00, 8'h00, 1, 0, 0, 0);

        // Re-enable I; IRQ entry with a same-cycle flag write that clears C and tries to set I.
        writeFlags(6'b100000, 6'b100000);
        flagWr   = 1'b1;
        flagMask = 6'b100001;
        flagIn   = 6'b100000;
        ack();
        flagWr   = 1'b0;
        flagMask = '0;
        flagIn   = '0;
        checkPacket("irq", 2'b10, 8'h00, 16'hFFFE);
        check("irq_flagsSaved", flagsSaved, 6'b100010);
        check("irq_flags", flags, 6'b000010);
        mFlags = 6'b000010;
        irq = 1'b0;
        ack();
        check("post_irq_readMem", readMem, 1);

        // Reset in the middle of operand fetch.
        memReady = 1'b1;
        intD     = 8'h85;
        tick();
        intD     = 8'h34;
        tick();
        memReady = 1'b0;
        check("mid_flags", flags, 6'b000010);
        resetReq = 1'b1;
        tick();
        check("mid_rst_valid", instValid, 0);
        check("mid_rst_readMem", readMem, 0);
        check("mid_rst_flags", flags, FLAGS_RESET);
        check("mid_rst_flagsSaved", flagsSaved, 0);
        resetReq = 1'b0;
        instAck  = 1'b1;
        tick();
        instAck  = 1'b0;
        checkPacket("mid_rst_pkt", 2'b11, 8'h00, 16'hFFFC);
        mFlags = FLAGS_RESET;
        ack();
        serveInst(8'h40, 8'h5A, 8'h00, 8'h00, 0, 0, 0, 0);
        check("final_flags", flags, mFlags);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
